// File: rtl/ma_pkg.sv
// Shared types and sizing helpers for the streaming moving-average filter.
package ma_pkg;

  typedef enum logic {
    MA_TRUNC = 1'b0,
    MA_RNDHU = 1'b1
  } ma_round_e;

  function automatic int unsigned ma_sum_w(input int unsigned w, input int unsigned log2n);
    return w + log2n;
  endfunction

  function automatic int unsigned ma_n(input int unsigned log2n);
    return 32'd1 << log2n;
  endfunction

  // Half an LSB of the shifted result; zero when truncating or when there is no shift.
  function automatic int unsigned ma_rnd(input int unsigned log2n, input ma_round_e mode);
    if (mode == MA_RNDHU && log2n != 0) return 32'd1 << (log2n - 1);
    return 32'd0;
  endfunction

endpackage

// File: rtl/ma_sample_ring.sv
// N-entry flop ring holding the sample history; exposes the oldest entry at the write pointer.
module ma_sample_ring
  import ma_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] oldest_o
);

  localparam int unsigned N  = ma_n(LOG2N);
  localparam int unsigned PW = (LOG2N == 0) ? 1 : LOG2N;

  logic [W-1:0]  ring_q [N];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] wp_d;

  // Pointer wraps naturally at N; a single-entry ring never advances.
  always_comb begin
    wp_d = wp_q;
    if (push_i && LOG2N != 0) wp_d = wp_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int i = 0; i < int'(N); i++) ring_q[i] <= '0;
      wp_q <= '0;
    end else begin
      if (push_i) ring_q[wp_q] <= data_i;
      wp_q <= wp_d;
    end
  end

  assign oldest_o = ring_q[wp_q];

endmodule

// File: rtl/moving_avg_stream.sv
// Streaming 2^LOG2N-point moving average with valid/ready handshake, optional rounding and flush.
module moving_avg_stream
  import ma_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2N = 2,
  parameter int unsigned ROUND = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y_out,
  output logic         warm
);

  localparam int unsigned SW = ma_sum_w(W, LOG2N);
  localparam int unsigned N  = ma_n(LOG2N);
  localparam int unsigned CW = LOG2N + 1;
  localparam logic [SW-1:0] RND = SW'(ma_rnd(LOG2N, (ROUND != 0) ? MA_RNDHU : MA_TRUNC));

  logic          accept;
  logic [W-1:0]  oldest;
  logic [SW-1:0] nxt;
  logic [SW-1:0] rounded;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          warm_q, warm_d;

  assign in_ready = !rst && !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  ma_sample_ring #(
    .W     (W),
    .LOG2N (LOG2N)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .push_i   (accept),
    .data_i   (x_in),
    .oldest_o (oldest)
  );

  // Running sum never underflows: it always contains the oldest entry being removed.
  always_comb begin
    nxt         = sum_q + SW'(x_in) - SW'(oldest);
    rounded     = nxt + RND;
    sum_d       = sum_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    warm_d      = warm_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = W'(rounded >> LOG2N);
      sum_d       = nxt;
      if (count_q != CW'(N)) count_d = count_q + CW'(1);
      warm_d = (count_d == CW'(N));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Flush drops history but leaves any pending result to be delivered.
    if (clear) begin
      sum_d   = '0;
      count_d = '0;
      warm_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      warm_q      <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      warm_q      <= warm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign warm      = warm_q;

endmodule

// File: tb/tb_moving_avg_stream.sv
// Five filter configurations share one stimulus stream; a history model feeds an output scoreboard.
module tb_moving_avg_stream;

  localparam int unsigned ND = 5;
  localparam int unsigned CL [ND] = '{2, 2, 0, 3, 5};
  localparam int unsigned CR [ND] = '{0, 1, 0, 0, 1};

  typedef logic [ND-1:0][7:0] exp_t;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, out_ready;
  logic [7:0] x_in;
  logic       ir [ND];
  logic       ov [ND];
  logic       wm [ND];
  logic [7:0] y  [ND];

  int   total = 0;
  int   bad   = 0;
  int   hist[$];
  exp_t sb[$];
  logic prev_hold = 1'b0;
  logic [7:0] prev_y = '0;

  always #5 clk = ~clk;

  moving_avg_stream #(.W(8), .LOG2N(2), .ROUND(0)) u0 (.clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir[0]), .x_in(x_in), .out_valid(ov[0]), .out_ready(out_ready),
    .y_out(y[0]), .warm(wm[0]));
  moving_avg_stream #(.W(8), .LOG2N(2), .ROUND(1)) u1 (.clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir[1]), .x_in(x_in), .out_valid(ov[1]), .out_ready(out_ready),
    .y_out(y[1]), .warm(wm[1]));
  moving_avg_stream #(.W(8), .LOG2N(0), .ROUND(0)) u2 (.clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir[2]), .x_in(x_in), .out_valid(ov[2]), .out_ready(out_ready),
    .y_out(y[2]), .warm(wm[2]));
  moving_avg_stream #(.W(8), .LOG2N(3), .ROUND(0)) u3 (.clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir[3]), .x_in(x_in), .out_valid(ov[3]), .out_ready(out_ready),
    .y_out(y[3]), .warm(wm[3]));
  moving_avg_stream #(.W(8), .LOG2N(5), .ROUND(1)) u4 (.clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(ir[4]), .x_in(x_in), .out_valid(ov[4]), .out_ready(out_ready),
    .y_out(y[4]), .warm(wm[4]));

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected averages for every configuration, from the accepted history since last flush.
  task automatic model_accept(input int x);
    exp_t e;
    int   s, n;
    hist.push_back(x);
    if (hist.size() > 32) void'(hist.pop_front());
    for (int i = 0; i < int'(ND); i++) begin
      n = 1 << CL[i];
      s = 0;
      for (int k = 0; k < n && k < hist.size(); k++) s += hist[hist.size() - 1 - k];
      if (CR[i] != 0 && CL[i] > 0) s += 1 << (CL[i] - 1);
      e[i] = 8'(s >> CL[i]);
    end
    sb.push_back(e);
  endtask

  // Present a sample, wait (bounded) for acceptance; leaves in_valid high for back-to-back use.
  task automatic send(input int x);
    int n = 0;
    in_valid = 1'b1;
    x_in = 8'(x);
    #1;
    while (!ir[0] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ir[0]) check_eq("send_timeout", 0, 1);
    else model_accept(x);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    sb.delete();
    hist.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Output monitor: pop on each transfer, and require stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (prev_hold) begin
        check_eq("hold_valid", int'(ov[0]), 1);
        check_eq("hold_y", int'(y[0]), int'(prev_y));
      end
      if (ov[0] && out_ready) begin
        if (sb.size() == 0) check_eq("sb_empty", 1, 0);
        else begin
          e = sb.pop_front();
          for (int i = 0; i < int'(ND); i++) check_eq($sformatf("y_cfg%0d", i), int'(y[i]), int'(e[i]));
        end
      end
      prev_hold = ov[0] && !out_ready;
      prev_y = y[0];
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1x [5] = '{4, 8, 12, 16, 20};
    int t1y [5] = '{1, 3, 6, 10, 14};
    int t2y [6] = '{63, 127, 191, 255, 255, 255};
    int t3x [4] = '{1, 1, 1, 2};
    int t3r [4] = '{0, 1, 1, 1};
    int t3t [4] = '{0, 0, 0, 1};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_valid", int'(ov[0]), 0);
    check_eq("rst_y", int'(y[0]), 0);
    check_eq("rst_warm", int'(wm[0]), 0);
    check_eq("rst_in_ready", int'(ir[0]), 1);
    @(negedge clk);

    // Ramp: warm rises on the edge that accepts the fourth sample.
    for (int i = 0; i < 5; i++) begin
      send(t1x[i]);
      check_eq("ramp_y", int'(y[0]), t1y[i]);
      check_eq("ramp_warm", int'(wm[0]), (i >= 3) ? 1 : 0);
    end
    in_valid = 1'b0;

    // Full-scale input must not wrap.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(255);
      check_eq("fullscale_y", int'(y[0]), t2y[i]);
    end
    in_valid = 1'b0;

    // Round-half-up versus truncate.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(t3x[i]);
      check_eq("round_y", int'(y[1]), t3r[i]);
      check_eq("trunc_y", int'(y[0]), t3t[i]);
    end
    in_valid = 1'b0;

    // Backpressure: stall three cycles with a sample waiting.
    do_reset();
    send(50);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x_in = 8'd70;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_in_ready", int'(ir[0]), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(70 + 10 * i);
    in_valid = 1'b0;

    // Flush after ten samples; the coincident sample is refused.
    do_reset();
    for (int i = 0; i < 10; i++) send(3 * i + 5);
    check_eq("pre_clear_warm", int'(wm[0]), 1);
    clear = 1'b1;
    in_valid = 1'b1;
    x_in = 8'd99;
    #1;
    check_eq("clear_in_ready", int'(ir[0]), 0);
    hist.delete();
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("clear_warm", int'(wm[0]), 0);
    @(negedge clk);
    send(40);
    check_eq("post_clear_y", int'(y[0]), 10);
    in_valid = 1'b0;

    // Mid-stream reset with a stalled pending result.
    for (int i = 0; i < 4; i++) send(100);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("pre_rst_valid", int'(ov[0]), 1);
    check_eq("pre_rst_warm", int'(wm[0]), 1);
    @(negedge clk);
    do_reset();
    #1;
    check_eq("midrst_valid", int'(ov[0]), 0);
    check_eq("midrst_y", int'(y[0]), 0);
    check_eq("midrst_warm", int'(wm[0]), 0);
    check_eq("midrst_in_ready", int'(ir[0]), 1);
    out_ready = 1'b1;
    @(negedge clk);

    // Random traffic with random stalls, flushes and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(149) == 0) begin
        do_reset();
      end else begin
        out_ready = ($urandom_range(3) != 0);
        in_valid  = ($urandom_range(3) != 0);
        x_in      = 8'($urandom_range(255));
        clear     = ($urandom_range(39) == 0);
        #1;
        if (clear) hist.delete();
        else if (in_valid && ir[0]) model_accept(int'(x_in));
        @(negedge clk);
      end
    end
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_eq("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
